// File: rtl/dma_priority_arbiter_if.sv
// Signal bundle between the DMA priority arbiter, the CPU hold handshake and timing control.
// Define DMA_SW_REQUEST_EN to add the software request bits (swReqReg).
interface dma_priority_arbiter_if;
    logic [3:0] DREQ;
    logic       HLDA;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       dreqSenseHigh;
    logic       dackSenseHigh;
    logic       controllerDisable;
    logic       assertDACK;
    logic       serviceDone;
`ifdef DMA_SW_REQUEST_EN
    logic [3:0] swReqReg;
`endif
    logic       HRQ;
    logic [3:0] DACK;
    logic       svcValid;
    logic [1:0] activeChannel;
    logic [7:0] priorityOrder;

`ifdef DMA_SW_REQUEST_EN
    modport master (
        input  DREQ, HLDA, maskReg, priorityType, dreqSenseHigh, dackSenseHigh,
               controllerDisable, assertDACK, serviceDone, swReqReg,
        output HRQ, DACK, svcValid, activeChannel, priorityOrder
    );
    modport slave (
        output DREQ, HLDA, maskReg, priorityType, dreqSenseHigh, dackSenseHigh,
               controllerDisable, assertDACK, serviceDone, swReqReg,
        input  HRQ, DACK, svcValid, activeChannel, priorityOrder
    );
`else
    modport master (
        input  DREQ, HLDA, maskReg, priorityType, dreqSenseHigh, dackSenseHigh,
               controllerDisable, assertDACK, serviceDone,
        output HRQ, DACK, svcValid, activeChannel, priorityOrder
    );
    modport slave (
        output DREQ, HLDA, maskReg, priorityType, dreqSenseHigh, dackSenseHigh,
               controllerDisable, assertDACK, serviceDone,
        input  HRQ, DACK, svcValid, activeChannel, priorityOrder
    );
`endif
endinterface

// File: rtl/dma_priority_arbiter.sv
// Priority resolution and HRQ/HLDA hold handshake for the 4-channel DMA controller.
// Define DMA_SW_REQUEST_EN to OR software requests (swReqReg) into the effective request vector.
module dma_priority_arbiter #(
    parameter int         NUM_CH     = 4,
    parameter logic [7:0] PRIO_RESET = 8'b11_10_01_00
) (
    input logic                    CLK,
    input logic                    RESET_N,
    dma_priority_arbiter_if.master bus
);
    localparam logic [7:0] PRIO_FIXED = 8'b11_10_01_00;

    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              hrq_q, hrq_d;
    logic              svc_valid_q, svc_valid_d;
    logic [1:0]        active_ch_q, active_ch_d;
    logic [3:0]        dack_q, dack_d;
    logic [7:0]        prio_q, prio_d;

    logic [NUM_CH-1:0] eff_req;
    logic [7:0]        prio_use;
    logic              win_found;
    logic [1:0]        win_ch;

    // Walk from lowest to highest priority so the highest-priority hit is the last assignment.
    function automatic logic [2:0] resolve(input logic [7:0] order, input logic [3:0] req);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (req[order[2*i +: 2]]) r = {1'b1, order[2*i +: 2]};
        end
        return r;
    endfunction

    // Move the served channel to the lowest-priority field, keeping the others in order.
    function automatic logic [7:0] rotate_after(input logic [7:0] order, input logic [1:0] ch);
        logic [7:0] r;
        r = order;
        if (ch == order[1:0])      r = {order[1:0], order[7:2]};
        else if (ch == order[3:2]) r = {order[3:0], order[7:4]};
        else if (ch == order[5:4]) r = {order[5:0], order[7:6]};
        return r;
    endfunction

    always_comb begin
        eff_req = (bus.DREQ ^ {4{~bus.dreqSenseHigh}}) & ~bus.maskReg;
`ifdef DMA_SW_REQUEST_EN
        eff_req = eff_req | bus.swReqReg;
`endif
    end

    always_comb begin
        prio_use               = bus.priorityType ? prio_q : PRIO_FIXED;
        {win_found, win_ch}    = resolve(prio_use, eff_req);
        state_d                = state_q;
        hrq_d                  = hrq_q;
        svc_valid_d            = svc_valid_q;
        active_ch_d            = active_ch_q;
        prio_d                 = prio_use;
        dack_d                 = {4{~bus.dackSenseHigh}};
        case (state_q)
            IDLE: begin
                hrq_d       = 1'b0;
                svc_valid_d = 1'b0;
                if (|eff_req && !bus.controllerDisable) begin
                    state_d = REQ;
                    hrq_d   = 1'b1;
                end
            end
            REQ: begin
                if (bus.HLDA) begin
                    if (win_found) begin
                        state_d     = GRANT;
                        active_ch_d = win_ch;
                        svc_valid_d = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        hrq_d   = 1'b0;
                    end
                end
            end
            GRANT: begin
                if (bus.assertDACK) dack_d[active_ch_q] = bus.dackSenseHigh;
                // serviceDone takes precedence over a simultaneous HLDA drop.
                if (bus.serviceDone) begin
                    state_d     = RELEASE;
                    hrq_d       = 1'b0;
                    svc_valid_d = 1'b0;
                    if (bus.priorityType) prio_d = rotate_after(prio_q, active_ch_q);
                end else if (!bus.HLDA) begin
                    state_d     = IDLE;
                    hrq_d       = 1'b0;
                    svc_valid_d = 1'b0;
                end
            end
            RELEASE: begin
                hrq_d       = 1'b0;
                svc_valid_d = 1'b0;
                if (!bus.HLDA) state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                hrq_d       = 1'b0;
                svc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            hrq_q       <= 1'b0;
            svc_valid_q <= 1'b0;
            active_ch_q <= 2'd0;
            dack_q      <= 4'b0000;
            prio_q      <= PRIO_RESET;
        end else begin
            state_q     <= state_d;
            hrq_q       <= hrq_d;
            svc_valid_q <= svc_valid_d;
            active_ch_q <= active_ch_d;
            dack_q      <= dack_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.HRQ           = hrq_q;
    assign bus.DACK          = dack_q;
    assign bus.svcValid      = svc_valid_q;
    assign bus.activeChannel = active_ch_q;
    assign bus.priorityOrder = prio_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed-vector bench for dma_priority_arbiter; one task per scenario with inline checks.
// Build with DMA_SW_REQUEST_EN defined to exercise software requests.
module tb_dma_priority_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    dma_priority_arbiter_if ifc();

    dma_priority_arbiter dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.dackSenseHigh = 1'b0;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL reset_hrq got=%b want=0", ifc.HRQ); end
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL reset_dack got=%b want=0000", ifc.DACK); end
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL reset_svc got=%b want=0", ifc.svcValid); end
        total++; if (ifc.activeChannel !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d want=0", ifc.activeChannel); end
        total++; if (ifc.priorityOrder !== 8'b11_10_01_00) begin bad++; $display("FAIL reset_prio got=%b want=11100100", ifc.priorityOrder); end
        rst_n = 1'b1;
        step();
        total++; if (ifc.DACK !== 4'b1111) begin bad++; $display("FAIL post_reset_dack_low got=%b want=1111", ifc.DACK); end
        ifc.dackSenseHigh = 1'b1;
        step();
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL post_reset_dack_high got=%b want=0000", ifc.DACK); end
    endtask

    task automatic test_fixed();
        ifc.priorityType = 1'b0;
        ifc.DREQ = 4'b1110;
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL fixed_hrq got=%b want=1", ifc.HRQ); end
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL fixed_svc_req got=%b want=0", ifc.svcValid); end
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.svcValid !== 1'b1) begin bad++; $display("FAIL fixed_svc got=%b want=1", ifc.svcValid); end
        total++; if (ifc.activeChannel !== 2'd1) begin bad++; $display("FAIL fixed_ch got=%0d want=1", ifc.activeChannel); end
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL fixed_dack_idle got=%b want=0000", ifc.DACK); end
        ifc.assertDACK = 1'b1;
        ifc.DREQ = 4'b0001;
        step();
        total++; if (ifc.DACK !== 4'b0010) begin bad++; $display("FAIL fixed_dack got=%b want=0010", ifc.DACK); end
        total++; if (ifc.activeChannel !== 2'd1) begin bad++; $display("FAIL fixed_ch_frozen got=%0d want=1", ifc.activeChannel); end
        ifc.assertDACK = 1'b0;
        ifc.serviceDone = 1'b1;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL fixed_release_hrq got=%b want=0", ifc.HRQ); end
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL fixed_release_svc got=%b want=0", ifc.svcValid); end
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL fixed_release_dack got=%b want=0000", ifc.DACK); end
        total++; if (ifc.priorityOrder !== 8'b11_10_01_00) begin bad++; $display("FAIL fixed_prio got=%b want=11100100", ifc.priorityOrder); end
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        ifc.DREQ = 4'b0000;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL fixed_idle_hrq got=%b want=0", ifc.HRQ); end
    endtask

    task automatic test_rotation();
        ifc.priorityType = 1'b1;
        ifc.DREQ = 4'b1111;
        step();
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.activeChannel !== 2'd0) begin bad++; $display("FAIL rot_ch0 got=%0d want=0", ifc.activeChannel); end
        ifc.serviceDone = 1'b1;
        step();
        total++; if (ifc.priorityOrder !== 8'b00_11_10_01) begin bad++; $display("FAIL rot_prio1 got=%b want=00111001", ifc.priorityOrder); end
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL rot_gap_hrq got=%b want=0", ifc.HRQ); end
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL rot_rereq_hrq got=%b want=1", ifc.HRQ); end
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.activeChannel !== 2'd1) begin bad++; $display("FAIL rot_ch1 got=%0d want=1", ifc.activeChannel); end
        ifc.serviceDone = 1'b1;
        step();
        total++; if (ifc.priorityOrder !== 8'b01_00_11_10) begin bad++; $display("FAIL rot_prio2 got=%b want=01001110", ifc.priorityOrder); end
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        ifc.DREQ = 4'b0000;
        ifc.priorityType = 1'b0;
        step();
        total++; if (ifc.priorityOrder !== 8'b11_10_01_00) begin bad++; $display("FAIL rot_fixed_restore got=%b want=11100100", ifc.priorityOrder); end
    endtask

    task automatic test_mask_polarity();
        ifc.dreqSenseHigh = 1'b0;
        ifc.dackSenseHigh = 1'b0;
        ifc.DREQ = 4'b1011;
        ifc.maskReg = 4'b1000;
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL pol_hrq got=%b want=1", ifc.HRQ); end
        total++; if (ifc.DACK !== 4'b1111) begin bad++; $display("FAIL pol_dack_idle got=%b want=1111", ifc.DACK); end
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.activeChannel !== 2'd2) begin bad++; $display("FAIL pol_ch got=%0d want=2", ifc.activeChannel); end
        ifc.assertDACK = 1'b1;
        step();
        total++; if (ifc.DACK !== 4'b1011) begin bad++; $display("FAIL pol_dack got=%b want=1011", ifc.DACK); end
        ifc.assertDACK = 1'b0;
        step();
        total++; if (ifc.DACK !== 4'b1111) begin bad++; $display("FAIL pol_dack_drop got=%b want=1111", ifc.DACK); end
        ifc.serviceDone = 1'b1;
        step();
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        ifc.dreqSenseHigh = 1'b1;
        ifc.DREQ = 4'b0000;
        ifc.maskReg = 4'b0000;
        step();
        ifc.dackSenseHigh = 1'b1;
        step();
    endtask

    task automatic test_withdrawn();
        ifc.DREQ = 4'b0001;
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL wd_hrq got=%b want=1", ifc.HRQ); end
        ifc.DREQ = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL wd_svc_wait got=%b want=0", ifc.svcValid); end
        end
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL wd_release_hrq got=%b want=0", ifc.HRQ); end
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL wd_release_svc got=%b want=0", ifc.svcValid); end
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL wd_hold_hrq got=%b want=0", ifc.HRQ); end
        ifc.HLDA = 1'b0;
        step();
    endtask

    task automatic test_disable();
        ifc.controllerDisable = 1'b1;
        ifc.DREQ = 4'b0001;
        step();
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL dis_block_hrq got=%b want=0", ifc.HRQ); end
        ifc.controllerDisable = 1'b0;
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL dis_req_hrq got=%b want=1", ifc.HRQ); end
        ifc.controllerDisable = 1'b1;
        ifc.assertDACK = 1'b1;
        step();
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL dis_dack_req got=%b want=0000", ifc.DACK); end
        ifc.assertDACK = 1'b0;
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.svcValid !== 1'b1) begin bad++; $display("FAIL dis_grant_svc got=%b want=1", ifc.svcValid); end
        ifc.serviceDone = 1'b1;
        ifc.HLDA = 1'b0;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL dis_done_hrq got=%b want=0", ifc.HRQ); end
        ifc.serviceDone = 1'b0;
        ifc.controllerDisable = 1'b0;
        ifc.DREQ = 4'b0000;
        step();
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL dis_idle_svc got=%b want=0", ifc.svcValid); end
    endtask

    task automatic test_sw_request();
        ifc.DREQ = 4'b0000;
        ifc.maskReg = 4'b1111;
`ifdef DMA_SW_REQUEST_EN
        ifc.swReqReg = 4'b0100;
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL sw_hrq got=%b want=1", ifc.HRQ); end
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.activeChannel !== 2'd2) begin bad++; $display("FAIL sw_ch got=%0d want=2", ifc.activeChannel); end
        ifc.serviceDone = 1'b1;
        step();
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        ifc.swReqReg = 4'b0000;
        step();
`else
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL sw_absent_hrq got=%b want=0", ifc.HRQ); end
        end
`endif
        ifc.maskReg = 4'b0000;
        step();
    endtask

    task automatic test_abort_reset();
        ifc.dackSenseHigh = 1'b0;
        ifc.priorityType = 1'b1;
        ifc.DREQ = 4'b0010;
        step();
        ifc.HLDA = 1'b1;
        step();
        ifc.serviceDone = 1'b1;
        step();
        total++; if (ifc.priorityOrder !== 8'b01_00_11_10) begin bad++; $display("FAIL abort_rot_prio got=%b want=01001110", ifc.priorityOrder); end
        ifc.serviceDone = 1'b0;
        ifc.HLDA = 1'b0;
        step();
        step();
        ifc.HLDA = 1'b1;
        step();
        total++; if (ifc.activeChannel !== 2'd1) begin bad++; $display("FAIL abort_grant_ch got=%0d want=1", ifc.activeChannel); end
        ifc.HLDA = 1'b0;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL abort_hrq got=%b want=0", ifc.HRQ); end
        total++; if (ifc.svcValid !== 1'b0) begin bad++; $display("FAIL abort_svc got=%b want=0", ifc.svcValid); end
        total++; if (ifc.priorityOrder !== 8'b01_00_11_10) begin bad++; $display("FAIL abort_prio got=%b want=01001110", ifc.priorityOrder); end
        step();
        total++; if (ifc.HRQ !== 1'b1) begin bad++; $display("FAIL abort_rereq_hrq got=%b want=1", ifc.HRQ); end
        total++; if (ifc.DACK !== 4'b1111) begin bad++; $display("FAIL abort_dack_pre got=%b want=1111", ifc.DACK); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL async_hrq got=%b want=0", ifc.HRQ); end
        total++; if (ifc.DACK !== 4'b0000) begin bad++; $display("FAIL async_dack got=%b want=0000", ifc.DACK); end
        total++; if (ifc.priorityOrder !== 8'b11_10_01_00) begin bad++; $display("FAIL async_prio got=%b want=11100100", ifc.priorityOrder); end
        step();
        ifc.dackSenseHigh = 1'b1;
        ifc.priorityType = 1'b0;
        ifc.DREQ = 4'b0000;
        rst_n = 1'b1;
        step();
        total++; if (ifc.HRQ !== 1'b0) begin bad++; $display("FAIL post_async_hrq got=%b want=0", ifc.HRQ); end
    endtask

    initial begin
        rst_n                 = 1'b0;
        ifc.DREQ              = 4'b0000;
        ifc.HLDA              = 1'b0;
        ifc.maskReg           = 4'b0000;
        ifc.priorityType      = 1'b0;
        ifc.dreqSenseHigh     = 1'b1;
        ifc.dackSenseHigh     = 1'b1;
        ifc.controllerDisable = 1'b0;
        ifc.assertDACK        = 1'b0;
        ifc.serviceDone       = 1'b0;
`ifdef DMA_SW_REQUEST_EN
        ifc.swReqReg          = 4'b0000;
`endif
        test_reset();
        test_fixed();
        test_rotation();
        test_mask_polarity();
        test_withdrawn();
        test_disable();
        test_sw_request();
        test_abort_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
